edge_event_encoder: RTL

- Inverse of the analyzer's 2-to-4 decoder: converts per-channel activity back into a binary channel index.
- Samples an N-channel input bus and detects assertion edges.
- Priority-encodes pending edges, lowest index first, into a small FIFO.
- Presents events on a valid/ready stream for the analyzer capture/UART path.

---
 rtl/analyzer_pkg.sv | 27 ++
 rtl/edge_event_fifo.sv | 56 +++++
 rtl/edge_event_encoder.sv | 80 ++++++++
 3 files changed

// File: rtl/analyzer_pkg.sv
// Shared analyzer definitions: width helpers, channel polarity and the
// lowest-set-bit priority function used by the event encoders.
package analyzer_pkg;

  typedef enum logic {
    ACT_HIGH = 1'b0,
    ACT_LOW  = 1'b1
  } polarity_e;

  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = $clog2(MAX_CH);

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int lowest_set(input logic [MAX_CH-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_event_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module edge_event_fifo
  import analyzer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = fifo_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A pop in the same cycle never frees room for a push while full.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/edge_event_encoder.sv
// Synchronizes N channels, detects assertion edges, queues them in a pending
// mask and encodes the lowest pending channel into an event FIFO.
module edge_event_encoder
  import analyzer_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int FIFO_DEPTH = 4,
  parameter  int ACTIVE_LOW = 0,
  localparam int IDX_W      = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  in_ch,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam polarity_e POL = (ACTIVE_LOW != 0) ? ACT_LOW : ACT_HIGH;

  logic [N_CH-1:0]  norm;
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  prev;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  edge_det;
  logic [N_CH-1:0]  sel_onehot;
  logic [N_CH-1:0]  repeat_hit;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_go;
  logic             fifo_full;
  logic             fifo_empty;

  assign norm     = (POL == ACT_LOW) ? ~in_ch : in_ch;
  assign edge_det = s2 & ~prev & {N_CH{en}};

  // Encode only when something is pending and the FIFO can take it; while
  // full the pending bits simply wait.
  assign sel_go     = (|pending) & ~fifo_full;
  assign sel_idx    = IDX_W'(lowest_set(MAX_CH'(pending)));
  assign sel_onehot = sel_go ? (N_CH'(1) << sel_idx) : '0;
  assign repeat_hit = edge_det & pending & ~sel_onehot;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      s1      <= norm;
      s2      <= s1;
      prev    <= s2;
      pending <= (pending & ~sel_onehot) | edge_det;
      if (|repeat_hit)  ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  edge_event_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sel_go),
    .din   (sel_idx),
    .pop   (out_valid & out_ready),
    .dout  (out_idx),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;

endmodule
